// File: rtl/bfs_spill_ctrl_pkg.sv
// Shared bus opcodes, burst geometry and helpers for the BFS spill ring.
// Opcodes follow the memory bus command encoding used by the queue.
package bfs_spill_ctrl_pkg;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int SPILL_BEATS = 8;
    localparam logic [63:0] SPILL_SENTINEL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef logic [2:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(SPILL_BEATS - 1);

    // Byte address of one beat inside a 64-byte ring block; wraps at 32 bits.
    function automatic logic [31:0] spill_addr(
        input logic [31:0] base,
        input logic [31:0] blk,
        input beat_t       beat
    );
        return base + (blk << 6) + (32'(beat) << 3);
    endfunction

endpackage

// File: rtl/bfs_spill_ctrl_beat_buf.sv
// 8x64 beat register file shared by the spill and restore phases.
// Preset fills every entry with the nil-node sentinel in one cycle.
module spill_beat_buf
    import bfs_spill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  beat_t       waddr,
    input  logic [63:0] wdata,
    input  logic        preset,
    input  beat_t       raddr,
    output logic [63:0] rdata
);

    logic [63:0] mem_q [SPILL_BEATS];
    logic [63:0] mem_d [SPILL_BEATS];

    always_comb begin
        mem_d = mem_q;
        if (preset) begin
            for (int i = 0; i < SPILL_BEATS; i++) begin
                mem_d[i] = SPILL_SENTINEL;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SPILL_BEATS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bfs_spill_ctrl.sv
// Memory-side responder for BFS queue spill/restore: buffers 8-beat
// bursts and moves them to/from a circular block ring in memory.
module bfs_spill_ctrl
    import bfs_spill_ctrl_pkg::*;
#(
    parameter logic [31:0] SPILL_BASE   = 32'h8000_0000,
    parameter int          SPILL_BLOCKS = 256
) (
    input  logic        clk,
    input  logic        bfs_rst,
    input  logic        spill_req,
    input  logic        spill_op,
    input  logic [63:0] spill_data,
    input  logic        spill_done,
    output logic        dc_ready,
    output logic        dc_valid,
    output logic [1:0]  dc_op,
    output logic [63:0] dc_rdata,
    output logic        dc_rbuf_empty,
    output logic        spill_empty,
    output logic        spill_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [1:0]  mem_req_op,
    output logic [31:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);

    localparam int PW = $clog2(SPILL_BLOCKS);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(SPILL_BLOCKS);

    typedef enum logic [2:0] {
        IDLE,
        SP_FILL,
        SP_DRAIN,
        RS_ACK,
        RS_READ,
        RS_SEND
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    beat_t         beat_q, beat_d;
    logic [3:0]    issue_q, issue_d;
    beat_t         rsp_q, rsp_d;
    logic          err_q, err_d;
    logic          empty_q, empty_d;

    logic          buf_we;
    beat_t         buf_waddr;
    logic [63:0]   buf_wdata;
    logic          buf_preset;
    logic [63:0]   buf_rdata;
    logic          rd_issue;

    spill_beat_buf u_buf (
        .clk    (clk),
        .rst    (bfs_rst),
        .we     (buf_we),
        .waddr  (buf_waddr),
        .wdata  (buf_wdata),
        .preset (buf_preset),
        .raddr  (beat_q),
        .rdata  (buf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        beat_d        = beat_q;
        issue_d       = issue_q;
        rsp_d         = rsp_q;
        err_d         = err_q;
        buf_we        = 1'b0;
        buf_waddr     = beat_q;
        buf_wdata     = spill_data;
        buf_preset    = 1'b0;
        rd_issue      = 1'b0;
        dc_ready      = 1'b0;
        dc_valid      = 1'b0;
        dc_op         = 2'b00;
        dc_rdata      = '0;
        mem_req_valid = 1'b0;
        mem_req_op    = 2'b00;
        mem_req_addr  = '0;
        mem_req_wdata = '0;

        unique case (state_q)
            IDLE: begin
                beat_d  = '0;
                issue_d = '0;
                rsp_d   = '0;
                if (spill_req && !spill_op && count_q < FULL) begin
                    state_d = SP_FILL;
                end else if (spill_req && spill_op) begin
                    state_d = RS_ACK;
                end
            end
            SP_FILL: begin
                dc_ready = 1'b1;
                buf_we   = 1'b1;
                beat_d   = beat_q + 1'b1;
                // Done must mark beat 7 exactly; a dropped request is also a fault.
                if (spill_done != (beat_q == LAST_BEAT) || !spill_req) begin
                    err_d = 1'b1;
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = SP_DRAIN;
                end
            end
            SP_DRAIN: begin
                mem_req_valid = 1'b1;
                mem_req_op    = OP_WR;
                mem_req_addr  = spill_addr(SPILL_BASE, 32'(tail_q), beat_q);
                mem_req_wdata = buf_rdata;
                if (mem_req_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tail_d  = tail_q + 1'b1;
                        count_d = (count_q < FULL) ? count_q + 1'b1 : count_q;
                        state_d = IDLE;
                    end
                end
            end
            RS_ACK: begin
                dc_ready = 1'b1;
                if (count_q != '0) begin
                    state_d = RS_READ;
                end else begin
                    buf_preset = 1'b1;
                    state_d    = RS_SEND;
                end
            end
            RS_READ: begin
                rd_issue = !issue_q[3];
                if (rd_issue) begin
                    mem_req_valid = 1'b1;
                    mem_req_op    = OP_RD;
                    mem_req_addr  = spill_addr(SPILL_BASE, 32'(head_q),
                                               issue_q[2:0]);
                    if (mem_req_ready) begin
                        issue_d = issue_q + 1'b1;
                    end
                end
                if (mem_resp_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = rsp_q;
                    buf_wdata = mem_resp_data;
                    rsp_d     = rsp_q + 1'b1;
                    if (rsp_q == LAST_BEAT) begin
                        head_d  = head_q + 1'b1;
                        count_d = count_q - 1'b1;
                        state_d = RS_SEND;
                    end
                end
            end
            RS_SEND: begin
                dc_valid = 1'b1;
                dc_op    = OP_RD;
                dc_rdata = buf_rdata;
                beat_d   = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (bfs_rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
            issue_q <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            beat_q  <= beat_d;
            issue_q <= issue_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            empty_q <= empty_d;
        end
    end

    assign dc_rbuf_empty = !(state_q == RS_READ || state_q == RS_SEND);
    assign spill_empty   = empty_q;
    assign spill_err     = err_q;

endmodule

// File: tb/tb_bfs_spill_ctrl.sv
// Bench for bfs_spill_ctrl: table of spill/restore ops against a FIFO
// ring model, memory model with scoreboards, plus corner sequences.
module tb_bfs_spill_ctrl;
    import bfs_spill_ctrl_pkg::*;

    localparam int BLK = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        bfs_rst;
    logic        spill_req;
    logic        spill_op;
    logic [63:0] spill_data;
    logic        spill_done;
    logic        dc_ready;
    logic        dc_valid;
    logic [1:0]  dc_op;
    logic [63:0] dc_rdata;
    logic        dc_rbuf_empty;
    logic        spill_empty;
    logic        spill_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [1:0]  mem_req_op;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;

    bfs_spill_ctrl #(
        .SPILL_BASE   (BASE),
        .SPILL_BLOCKS (BLK)
    ) dut (
        .clk            (clk),
        .bfs_rst        (bfs_rst),
        .spill_req      (spill_req),
        .spill_op       (spill_op),
        .spill_data     (spill_data),
        .spill_done     (spill_done),
        .dc_ready       (dc_ready),
        .dc_valid       (dc_valid),
        .dc_op          (dc_op),
        .dc_rdata       (dc_rdata),
        .dc_rbuf_empty  (dc_rbuf_empty),
        .spill_empty    (spill_empty),
        .spill_err      (spill_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_op     (mem_req_op),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", name);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [63:0] data;
        int          due;
    } rsp_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [63:0] exp_dc[$];
    rsp_t        rsp_pend[$];
    logic [63:0] mem [logic [31:0]];
    int          cyc = 0;
    bit          bp = 1'b0;
    int          resp_cnt = 0;

    logic [63:0] fifo_m[$];
    int          head_m = 0;
    int          tail_m = 0;

    // Memory model and output monitor, both evaluated on the falling edge.
    initial begin
        wr_t         e;
        logic [63:0] rd;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_req_ready = bp ? cyc[0] : 1'b1;
            if (rsp_pend.size() > 0 && rsp_pend[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rsp_pend[0].data;
                void'(rsp_pend.pop_front());
                resp_cnt++;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = '0;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_op == OP_WR) begin
                    if (exp_wr.size() == 0) begin
                        flag("wr_unexp");
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", 64'(mem_req_addr), 64'(e.addr));
                        chk("wr_data", mem_req_wdata, e.data);
                    end
                    mem[mem_req_addr] = mem_req_wdata;
                end else begin
                    chk("rd_op", 64'(mem_req_op), 64'(OP_RD));
                    if (exp_rd.size() == 0) begin
                        flag("rd_unexp");
                    end else begin
                        chk("rd_addr", 64'(mem_req_addr),
                            64'(exp_rd.pop_front()));
                    end
                    rd = mem.exists(mem_req_addr) ? mem[mem_req_addr] : '0;
                    rsp_pend.push_back('{data: rd, due: cyc + 2});
                end
            end
            if (dc_valid) begin
                chk("dc_op", 64'(dc_op), 64'(OP_RD));
                chk("rbuf_busy", 64'(dc_rbuf_empty), 64'd0);
                if (exp_dc.size() == 0) begin
                    flag("dc_unexp");
                end else begin
                    chk("dc_rdata", dc_rdata, exp_dc.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        bfs_rst    = 1'b1;
        spill_req  = 1'b0;
        spill_op   = 1'b0;
        spill_done = 1'b0;
        spill_data = '0;
        @(negedge clk);
        exp_wr.delete();
        exp_rd.delete();
        exp_dc.delete();
        fifo_m.delete();
        head_m = 0;
        tail_m = 0;
        @(negedge clk);
        bfs_rst = 1'b0;
    endtask

    task automatic do_spill(input logic [63:0] seed, input int done_beat,
                            input int gap_beat);
        int i;
        int g;
        int lat;
        for (int b = 0; b < SPILL_BEATS; b++) begin
            exp_wr.push_back('{addr: BASE + 32'(tail_m) * 64 + 32'(b) * 8,
                               data: seed + 64'(b) + 1});
        end
        fifo_m.push_back(seed);
        tail_m = (tail_m + 1) % BLK;
        i = 0;
        g = 0;
        lat = -1;
        @(negedge clk);
        while (i < SPILL_BEATS && g < 40) begin
            spill_req  = (i != gap_beat);
            spill_op   = 1'b0;
            spill_data = seed + 64'(i) + 1;
            spill_done = (i == done_beat);
            if (dc_ready) begin
                if (lat < 0) lat = g;
                i++;
            end
            @(negedge clk);
            g++;
        end
        spill_req  = 1'b0;
        spill_done = 1'b0;
        chk("spill_beats", 64'(i), 64'(SPILL_BEATS));
        chk("spill_lat", 64'(lat), 64'd1);
        g = 0;
        while (exp_wr.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_wr.size() > 0) begin
            flag("wr_timeout");
            exp_wr.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_restore();
        logic [63:0] s;
        int g;
        int pulses;
        if (fifo_m.size() > 0) begin
            s = fifo_m.pop_front();
            for (int b = 0; b < SPILL_BEATS; b++) begin
                exp_rd.push_back(BASE + 32'(head_m) * 64 + 32'(b) * 8);
                exp_dc.push_back(s + 64'(b) + 1);
            end
            head_m = (head_m + 1) % BLK;
        end else begin
            for (int b = 0; b < SPILL_BEATS; b++) begin
                exp_dc.push_back(SPILL_SENTINEL);
            end
        end
        @(negedge clk);
        spill_req = 1'b1;
        spill_op  = 1'b1;
        g = 0;
        while (!dc_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        pulses = int'(dc_ready);
        @(negedge clk);
        spill_req = 1'b0;
        spill_op  = 1'b0;
        g = 0;
        while (exp_dc.size() > 0 && g < 200) begin
            pulses += int'(dc_ready);
            @(negedge clk);
            g++;
        end
        if (exp_dc.size() > 0) begin
            flag("dc_timeout");
            exp_dc.delete();
            exp_rd.delete();
        end
        @(negedge clk);
        chk("ack_pulses", 64'(pulses), 64'd1);
    endtask

    task automatic full_stall();
        @(negedge clk);
        spill_req  = 1'b1;
        spill_op   = 1'b0;
        spill_data = 64'hBAD;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stall_ready", 64'(dc_ready), 64'd0);
            chk("stall_memreq", 64'(mem_req_valid), 64'd0);
        end
        spill_req = 1'b0;
    endtask

    typedef struct {
        bit          op;
        bit          bp;
        logic [63:0] seed;
        bit          exp_empty;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int r0;
        bfs_rst    = 1'b0;
        spill_req  = 1'b0;
        spill_op   = 1'b0;
        spill_data = '0;
        spill_done = 1'b0;

        tbl[0]  = '{0, 0, 64'h0,                   0};
        tbl[1]  = '{1, 0, 64'h0,                   1};
        tbl[2]  = '{0, 1, 64'h0000_0000_0000_0100, 0};
        tbl[3]  = '{0, 1, 64'hA5A5_0000_0000_0200, 0};
        tbl[4]  = '{1, 1, 64'h0,                   0};
        tbl[5]  = '{0, 0, 64'h0000_0000_0000_0300, 0};
        tbl[6]  = '{0, 0, 64'h1234_5678_0000_0400, 0};
        tbl[7]  = '{1, 0, 64'h0,                   0};
        tbl[8]  = '{0, 0, 64'hFFFF_0000_0000_0500, 0};
        tbl[9]  = '{0, 1, 64'h0000_0000_0000_0600, 0};
        tbl[10] = '{1, 1, 64'h0,                   0};
        tbl[11] = '{0, 0, 64'h0000_0000_0000_0700, 0};
        tbl[12] = '{1, 0, 64'h0,                   0};
        tbl[13] = '{1, 1, 64'h0,                   0};
        tbl[14] = '{1, 0, 64'h0,                   0};
        tbl[15] = '{1, 0, 64'h0,                   1};
        tbl[16] = '{1, 0, 64'h0,                   1};

        do_reset();
        chk("rst_ready", 64'(dc_ready), 64'd0);
        chk("rst_valid", 64'(dc_valid), 64'd0);
        chk("rst_dc_op", 64'(dc_op), 64'd0);
        chk("rst_rdata", dc_rdata, 64'd0);
        chk("rst_rbuf_empty", 64'(dc_rbuf_empty), 64'd1);
        chk("rst_spill_empty", 64'(spill_empty), 64'd1);
        chk("rst_err", 64'(spill_err), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_op", 64'(mem_req_op), 64'd0);
        chk("rst_mem_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_mem_wdata", mem_req_wdata, 64'd0);

        for (int k = 0; k < 17; k++) begin
            if (k == 10) full_stall();
            bp = tbl[k].bp;
            if (tbl[k].op) do_restore();
            else do_spill(tbl[k].seed, 7, -1);
            chk("spill_empty", 64'(spill_empty), 64'(tbl[k].exp_empty));
            chk("rbuf_empty", 64'(dc_rbuf_empty), 64'd1);
        end
        bp = 1'b0;
        chk("err_clean", 64'(spill_err), 64'd0);

        do_reset();
        do_spill(64'h5000, 3, -1);
        chk("err_done3", 64'(spill_err), 64'd1);
        do_restore();
        chk("err_sticky", 64'(spill_err), 64'd1);
        do_reset();
        chk("err_clr", 64'(spill_err), 64'd0);
        do_spill(64'h6000, 7, 4);
        chk("err_gap", 64'(spill_err), 64'd1);
        do_restore();

        do_reset();
        do_spill(64'hC000, 7, -1);
        for (int b = 0; b < SPILL_BEATS; b++) begin
            exp_rd.push_back(BASE + 32'(head_m) * 64 + 32'(b) * 8);
        end
        r0 = resp_cnt;
        @(negedge clk);
        spill_req = 1'b1;
        spill_op  = 1'b1;
        g = 0;
        while (!dc_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        spill_req = 1'b0;
        spill_op  = 1'b0;
        g = 0;
        while (resp_cnt - r0 < 4 && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk("midrst_progress", 64'(resp_cnt - r0 >= 4), 64'd1);
        do_reset();
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("midrst_spill_empty", 64'(spill_empty), 64'd1);
        chk("midrst_rbuf_empty", 64'(dc_rbuf_empty), 64'd1);
        chk("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
        do_spill(64'hE000, 7, -1);
        do_restore();
        chk("final_empty", 64'(spill_empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bfs_spill_ctrl.md
Name: bfs_spill_ctrl

Overview:
- Memory-side responder for the BFS queue spill/restore interface.
- Spill: accepts 8-beat (64-bit) spill bursts from the queue and writes them to a circular block ring in a fixed memory region.
- Restore: reads the oldest stored block back and returns its 8 beats on the dc_* channel tagged OP_RD.
- Sits between the BFS queue and the memory request bus.

Parameters:
SPILL_BASE, 32'h8000_0000, byte base address of the spill ring (64-byte aligned)
SPILL_BLOCKS, 256, ring capacity in 64-byte blocks (power of two)

Ports:
clk  input  1  clock
bfs_rst  input  1  synchronous active-high reset
spill_req  input  1  queue requests a spill or restore
spill_op  input  1  0 = spill, 1 = restore
spill_data  input  64  spill beat from queue
spill_done  input  1  queue marks its last spill/restore beat
dc_ready  output  1  spill beat accepted / restore command accepted
dc_valid  output  1  restore beat valid
dc_op  output  2  OP_RD while dc_valid, else 0
dc_rdata  output  64  restore beat
dc_rbuf_empty  output  1  no restore beats buffered or outstanding
spill_empty  output  1  ring holds zero blocks
spill_err  output  1  sticky protocol error
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_op  output  2  OP_WR / OP_RD (buscmd.vh)
mem_req_addr  output  32  byte address
mem_req_wdata  output  64  write data
mem_resp_valid  input  1  read response valid (in order, no backpressure)
mem_resp_data  input  64  read response data

Behaviour:
- Clock clk; reset bfs_rst is synchronous, active-high.
- Reset state:
  - FSM to IDLE; head, tail, count and beat counter cleared; spill_err cleared.
  - All outputs 0, except dc_rbuf_empty = 1 and spill_empty = 1.
- State IDLE:
  - spill_req & ~spill_op & count < SPILL_BLOCKS -> SP_FILL.
  - spill_req & spill_op -> RS_ACK.
  - Spill request while ring is full: remain in IDLE with dc_ready = 0 (queue stalls).
- SP_FILL:
  - dc_ready = 1.
  - Each cycle, spill_data is written to buffer entry beat; beat increments.
  - Exactly 8 consecutive beats; after beat 7 -> SP_DRAIN.
  - spill_done on beat 7 is required. spill_done on any other beat sets spill_err.
- SP_DRAIN:
  - mem_req_valid = 1, mem_req_op = OP_WR, mem_req_addr = SPILL_BASE + tail*64 + beat*8, mem_req_wdata = buffer[beat].
  - beat advances on mem_req_ready.
  - After the 8th accepted write: tail++ (wraps mod SPILL_BLOCKS), count++, -> IDLE.
- RS_ACK:
  - dc_ready = 1 for exactly one cycle.
  - count > 0 -> RS_READ.
  - count == 0 -> RS_SEND, with the buffer preset to 64'hFFFF_FFFF_FFFF_FFFF (nil-node sentinel).
- RS_READ:
  - Issues 8 pipelined reads: mem_req_op = OP_RD, addr = SPILL_BASE + head*64 + issue*8; issue advances on mem_req_ready.
  - Responses fill the buffer in order, indexed by a separate response counter.
  - After the 8th response: head++ (wraps), count-- -> RS_SEND.
- RS_SEND:
  - dc_valid = 1 and dc_op = OP_RD on 8 consecutive cycles; dc_rdata = buffer[0..7].
  - No backpressure. Then -> IDLE.
- Status outputs:
  - dc_rbuf_empty = 0 from RS_ACK exit through the last RS_SEND beat; 1 otherwise.
  - spill_empty = (count == 0), registered.
- Boundary conditions:
  - mem_resp_valid outside RS_READ is dropped. This covers stale responses after a mid-operation reset.
  - spill_req deasserting mid-SP_FILL sets spill_err; the FSM still completes 8 beats.
  - Pointer wrap: head and tail are log2(SPILL_BLOCKS) bits. count is log2(SPILL_BLOCKS)+1 bits and saturates at SPILL_BLOCKS.
  - Addresses are computed in 32-bit arithmetic; overflow beyond 32 bits wraps.

Decomposition:
- Extend buscmd.vh with SPILL_BEATS = 8 and the sentinel value; reuse OP_RD and OP_WR from it.
- FSM state encodings are local to this module.
- One sub-module, spill_beat_buf: an 8x64 register file with write port, read port and preset. A single instance is shared by the spill and restore phases, since the two phases are mutually exclusive.

Test Plan:
- Spill then restore: after reset, spill beats 0x1..0x8 -> 8 writes to 0x8000_0000..0x8000_0038. Restore returns 0x1..0x8 on dc_valid with dc_op = OP_RD; spill_empty ends at 1.
- Ring wrap: with SPILL_BLOCKS = 4, run 5 spills interleaved with 2 restores. The 5th spill writes to base + 0; restores return blocks in FIFO order.
- Full stall: with 4 blocks stored, spill_req holds dc_ready = 0. One restore frees a block; the next cycle the spill proceeds.
- Empty restore: restore with count = 0 -> one dc_ready pulse, then 8 beats of all-ones; no mem_req issued.
- Backpressure and errors: mem_req_ready toggled 1/0 during drain and read gives correct addresses and data. spill_done asserted on beat 3 -> spill_err = 1 until bfs_rst.
- Mid-operation reset: bfs_rst during RS_READ with 3 responses still pending -> late responses ignored; spill_empty = 1, dc_rbuf_empty = 1.
